// File: rtl/data_mem_mmio_pkg.sv
// Shared constants and address decode for the MIPS data-memory stage.
// No logic state; decode is purely combinational.
// No flow control here; consumers own their handshakes.
package mips_mem_pkg;

  localparam logic [31:0] ADDR_TX_DATA   = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_TX_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] ADDR_CYCLE     = 32'hFFFF_FF08;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX_DATA,
    SEL_TX_STATUS,
    SEL_CYCLE,
    SEL_NONE
  } sel_t;

  // RAM occupies [0, ram_bytes); the MMIO registers sit at fixed addresses at the top.
  function automatic sel_t decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
    sel_t sel;
    if (addr < ram_bytes)             sel = SEL_RAM;
    else if (addr == ADDR_TX_DATA)    sel = SEL_TX_DATA;
    else if (addr == ADDR_TX_STATUS)  sel = SEL_TX_STATUS;
    else if (addr == ADDR_CYCLE)      sel = SEL_CYCLE;
    else                              sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Core-to-memory bus plus the debug TX byte stream.
// Loads are zero-latency; stores commit on the clock edge.
// TX stream uses valid/ready; the memory side never stalls the core.
interface data_mem_mmio_if;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output alu_out, write_data, mem_write, tx_ready,
    input  read_data, tx_data, tx_valid
  );

  modport slave (
    input  alu_out, write_data, mem_write, tx_ready,
    output read_data, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_mmio_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, head entry shown on dout.
// Push visible on the output one cycle after its edge (no bypass).
// Push while full is dropped unless a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs, so push+pop while full both proceed.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage cleared so dout reads 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory stage: word RAM plus MMIO (debug TX FIFO, loadable cycle counter).
// Reads are combinational (0 cycles); writes commit on the rising edge.
// TX drains on tx_valid && tx_ready; pushes to a full FIFO are dropped and flag ovf.
module data_mem_mmio
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input logic              clock,
  input logic              reset,
  data_mem_mmio_if.slave   bus
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  sel_t          sel;
  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   cycle_cnt;
  logic [31:0]   status;
  logic          wr_en;
  logic          ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_drop;

  assign sel     = decode_addr(bus.alu_out, RAM_BYTES);
  assign ram_idx = bus.alu_out[AW+1:2];
  // Stores issued while reset is held must not touch RAM or MMIO.
  assign wr_en   = bus.mem_write && !reset;
  assign tx_push = wr_en && (sel == SEL_TX_DATA);
  assign tx_pop  = !fifo_empty && bus.tx_ready;
  assign tx_drop = tx_push && !tx_pop && (fifo_count == CW'(FIFO_DEPTH));

  assign bus.tx_valid = !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .din   (bus.write_data[7:0]),
    .pop   (tx_pop),
    .dout  (bus.tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Word RAM, intentionally not reset; alu_out[1:0] is ignored.
  always_ff @(posedge clock) begin
    if (wr_en && (sel == SEL_RAM)) ram[ram_idx] <= bus.write_data;
  end

  // Free-running counter; a store to CYCLE wins over the increment.
  always_ff @(posedge clock) begin
    if (reset)                           cycle_cnt <= '0;
    else if (wr_en && (sel == SEL_CYCLE)) cycle_cnt <= bus.write_data;
    else                                 cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Sticky overflow; any store to TX_STATUS clears it.
  always_ff @(posedge clock) begin
    if (reset)                                ovf <= 1'b0;
    else if (wr_en && (sel == SEL_TX_STATUS)) ovf <= 1'b0;
    else if (tx_drop)                         ovf <= 1'b1;
  end

  // Status word layout.
  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf;
  end

  // Side-effect-free load mux; TX_DATA and unmapped addresses read 0.
  always_comb begin
    bus.read_data = '0;
    unique case (sel)
      SEL_RAM:       bus.read_data = ram[ram_idx];
      SEL_TX_STATUS: bus.read_data = status;
      SEL_CYCLE:     bus.read_data = cycle_cnt;
      default:       ;
    endcase
  end
endmodule
